// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmitter, 8N1 frames (8E1 when UART_TX_PARITY_EN is defined)
module uart_tx_framer #(
    parameter int CLK_FREQ = 25000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy
);

    localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("uart_tx_framer: DIV must be at least 2");
        end
    endgenerate

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t        state;
    logic [DW-1:0] div_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
`ifdef UART_TX_PARITY_EN
    logic          parity;
`endif

    // Every bit ends when div_cnt wraps, so each bit is exactly DIV cycles long.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            in_ready <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        shift    <= in_data;
`ifdef UART_TX_PARITY_EN
                        parity   <= ^in_data;
`endif
                        state    <= S_START;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                S_START: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        state   <= S_DATA;
                        tx      <= shift[0];
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        shift   <= {1'b0, shift[7:1]};
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= S_PARITY;
                            tx    <= parity;
`else
                            state <= S_STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= shift[1];
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        state   <= S_STOP;
                        tx      <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
